spk_out_mc: RTL and testbench

- Multi-channel successor of the node spike-output sender.
- Merges NCH soma fire channels plus the config flit path into one internal flit FIFO, using round-robin arbitration.
- Multicasts each non-READ flit over a destination-table list terminated by a last flag, under credit-based flow control toward the node NI.
- Adds three behaviours: empty-table discard, end-of-table wrap termination, and saturating credits.

---
 rtl/spk_out_mc_if.sv | 38 +++
 rtl/spk_out_mc.sv | 248 ++++++++++++++++++++++++
 tb/tb_spk_out_mc.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spk_out_mc_if.sv
// Bus bundle of spk_out_mc: soma fire inputs, config flit path, dst table access,
// credit return and the outgoing flit stream toward the node NI.
interface spk_out_mc_if #(
   parameter int FW        = 59,
   parameter int SW        = 24,
   parameter int NCH       = 4,
   parameter int DST_WIDTH = 21,
   parameter int DST_AW    = 4
);
   logic                 credit_in;
   logic                 flit_out_wr;
   logic [FW-1:0]        flit_out;
   logic [NCH-1:0]       soma_fire;
   logic [NCH*SW-1:0]    soma_neuid;
   logic                 cfg_we;
   logic [FW-1:0]        cfg_wdata;
   logic                 cfg_full;
   logic                 dst_we;
   logic [DST_AW-1:0]    dst_waddr;
   logic [DST_WIDTH-1:0] dst_wdata;
   logic                 dst_re;
   logic [DST_AW-1:0]    dst_raddr;
   logic [DST_WIDTH-1:0] dst_rdata;
   logic                 dst_rvalid;
   logic                 busy;

   modport slave (
      input  credit_in, soma_fire, soma_neuid, cfg_we, cfg_wdata,
             dst_we, dst_waddr, dst_wdata, dst_re, dst_raddr,
      output flit_out_wr, flit_out, cfg_full, dst_rdata, dst_rvalid, busy
   );

   modport master (
      output credit_in, soma_fire, soma_neuid, cfg_we, cfg_wdata,
             dst_we, dst_waddr, dst_wdata, dst_re, dst_raddr,
      input  flit_out_wr, flit_out, cfg_full, dst_rdata, dst_rvalid, busy
   );
endinterface

// File: rtl/spk_out_mc.sv
// Multi-channel spike-output sender: round-robin merge of soma fires and config flits
// into a flit FIFO, multicast over a dst table with credit flow control.
// Optional statistics counters are enabled by defining SPK_OUT_MC_STATS_EN.
module spk_out_mc #(
   parameter int FW        = 59,
   parameter int FTW       = 3,
   parameter int SW        = 24,
   parameter int NCH       = 4,
   parameter int FIFO_AW   = 4,
   parameter int DST_WIDTH = 21,
   parameter int DST_AW    = 4,
   parameter int R_FLG     = 36,
   parameter int CREDIT_W  = 4
) (
   input  logic        clk,
   input  logic        rst,
`ifdef SPK_OUT_MC_STATS_EN
   input  logic        stat_clr,
   output logic [15:0] stat_drop_cnt,
   output logic [15:0] stat_flit_cnt,
`endif
   spk_out_mc_if.slave bus
);
   localparam int FIFO_DEPTH = 1 << FIFO_AW;
   localparam int TBL_DEPTH  = 1 << DST_AW;
   localparam int RRW        = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [FTW-1:0] TYPE_READ = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND} FsmStateT;

   logic [NCH-1:0]       r_pending;
   logic [SW-1:0]        r_hold [NCH];
   logic [RRW-1:0]       r_rr;
   logic [FW-1:0]        r_fifoMem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]   r_wrPtr;
   logic [FIFO_AW-1:0]   r_rdPtr;
   logic [FIFO_AW:0]     r_count;
   logic [DST_WIDTH-1:0] r_table [TBL_DEPTH];
   logic                 r_tableValid;
   logic [DST_WIDTH-1:0] r_dstRdata;
   logic                 r_dstRvalid;
   FsmStateT             r_state;
   logic [FW-1:0]        r_cur;
   logic                 r_isRead;
   logic [DST_AW-1:0]    r_addr;
   logic [DST_WIDTH-1:0] r_ent;
   logic [FW-1:0]        r_flitOut;
   logic                 r_flitOutWr;
   logic [CREDIT_W-1:0]  r_credit;

   logic                 w_fifoEmpty;
   logic                 w_fifoFull;
   logic                 w_grantFound;
   logic [RRW-1:0]       w_grantIdx;
   logic [RRW-1:0]       w_rrNext;
   logic [NCH-1:0]       w_grantOh;
   logic [NCH-1:0]       w_accept;
   logic                 w_cfgPush;
   logic                 w_somaPush;
   logic                 w_push;
   logic                 w_pop;
   logic [FW-1:0]        w_pushData;
   logic [FW-1:0]        w_head;
   logic                 w_headIsRead;

   assign w_fifoEmpty  = (r_count == '0);
   assign w_fifoFull   = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
   assign w_cfgPush    = bus.cfg_we && !w_fifoFull;
   assign w_somaPush   = !bus.cfg_we && !w_fifoFull && w_grantFound;
   assign w_push       = w_cfgPush || w_somaPush;
   assign w_pop        = (r_state == ST_IDLE) && !w_fifoEmpty;
   assign w_head       = r_fifoMem[r_rdPtr];
   assign w_headIsRead = (w_head[FW-1:FW-FTW] == TYPE_READ);
   assign w_pushData   = bus.cfg_we ? bus.cfg_wdata : {{(FW-SW){1'b0}}, r_hold[w_grantIdx]};
   assign w_rrNext     = (w_grantIdx == RRW'(NCH-1)) ? '0 : w_grantIdx + RRW'(1);

   // Round robin: first pass looks at channels at or above the pointer, second pass wraps.
   always_comb begin
      w_grantFound = 1'b0;
      w_grantIdx   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!w_grantFound && r_pending[i] && (i >= int'(r_rr))) begin
            w_grantFound = 1'b1;
            w_grantIdx   = RRW'(i);
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (!w_grantFound && r_pending[i]) begin
            w_grantFound = 1'b1;
            w_grantIdx   = RRW'(i);
         end
      end
   end

   always_comb begin
      w_grantOh = '0;
      if (w_somaPush) w_grantOh[w_grantIdx] = 1'b1;
   end

   // A fire lands when the channel is free or is being granted this very cycle.
   assign w_accept = bus.soma_fire & (~r_pending | w_grantOh);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
         r_rr      <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_accept[i]) r_pending[i] <= 1'b1;
            else if (w_grantOh[i]) r_pending[i] <= 1'b0;
         end
         if (w_somaPush) r_rr <= w_rrNext;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (w_accept[i]) r_hold[i] <= bus.soma_neuid[i*SW +: SW];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifoMem[r_wrPtr] <= w_pushData;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + FIFO_AW'(1);
         if (w_pop) r_rdPtr <= r_rdPtr + FIFO_AW'(1);
         if (w_push && !w_pop) r_count <= r_count + (FIFO_AW+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (FIFO_AW+1)'(1);
      end
   end

   // Table contents deliberately survive reset; only the valid flag is cleared.
   always_ff @(posedge clk) begin
      if (bus.dst_we) r_table[bus.dst_waddr] <= bus.dst_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tableValid <= 1'b0;
         r_dstRdata   <= '0;
         r_dstRvalid  <= 1'b0;
      end else begin
         if (bus.dst_we) r_tableValid <= 1'b1;
         r_dstRdata  <= r_table[bus.dst_raddr];
         r_dstRvalid <= bus.dst_re;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_isRead    <= 1'b0;
         r_addr      <= '0;
         r_ent       <= '0;
         r_flitOut   <= '0;
         r_flitOutWr <= 1'b0;
      end else begin
         r_flitOutWr <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (!w_fifoEmpty) begin
                  r_cur    <= w_head;
                  r_addr   <= '0;
                  r_isRead <= w_headIsRead;
                  if (w_headIsRead) r_state <= ST_WAIT;
                  else if (r_tableValid) r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               r_ent   <= r_table[r_addr];
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_credit != '0) begin
                  r_flitOut   <= r_isRead ? r_cur
                               : {r_cur[FW-1:FW-FTW], r_ent[DST_WIDTH-1:1], r_cur[R_FLG-1:0]};
                  r_flitOutWr <= 1'b1;
                  r_state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (r_isRead || r_ent[0] || (r_addr == '1)) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_addr  <= r_addr + DST_AW'(1);
                  r_state <= ST_FETCH;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A returned credit and a sent flit in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credit <= '1;
      end else if (bus.credit_in && !r_flitOutWr) begin
         if (r_credit != '1) r_credit <= r_credit + CREDIT_W'(1);
      end else if (!bus.credit_in && r_flitOutWr) begin
         r_credit <= r_credit - CREDIT_W'(1);
      end
   end

`ifdef SPK_OUT_MC_STATS_EN
   logic [15:0] r_dropCnt;
   logic [15:0] r_flitCnt;
   logic [NCH-1:0] w_dropFires;
   logic        w_discard;
   logic        w_cfgIgnored;
   logic [5:0]  w_dropInc;
   logic [16:0] w_dropSum;

   assign w_dropFires  = bus.soma_fire & r_pending & ~w_grantOh;
   assign w_discard    = w_pop && !w_headIsRead && !r_tableValid;
   assign w_cfgIgnored = bus.cfg_we && w_fifoFull;
   assign w_dropInc    = 6'($countones(w_dropFires)) + 6'(w_discard) + 6'(w_cfgIgnored);
   assign w_dropSum    = {1'b0, r_dropCnt} + 17'(w_dropInc);

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         r_dropCnt <= '0;
         r_flitCnt <= '0;
      end else begin
         r_dropCnt <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
         if (r_flitOutWr && (r_flitCnt != 16'hFFFF)) r_flitCnt <= r_flitCnt + 16'd1;
      end
   end

   assign stat_drop_cnt = r_dropCnt;
   assign stat_flit_cnt = r_flitCnt;
`endif

   assign bus.flit_out_wr = r_flitOutWr;
   assign bus.flit_out    = r_flitOut;
   assign bus.cfg_full    = (r_count >= (FIFO_AW+1)'(FIFO_DEPTH-1));
   assign bus.dst_rdata   = r_dstRdata;
   assign bus.dst_rvalid  = r_dstRvalid;
   assign bus.busy        = (r_state != ST_IDLE) || !w_fifoEmpty || (|r_pending);
endmodule

// File: tb/tb_spk_out_mc.sv
// Directed bench for spk_out_mc: a flit-list model predicts every outgoing flit in order,
// plus literal checks on latency, ordering, credit stall, wrap and drop behaviour.
module tb_spk_out_mc;
   localparam int FW = 59, FTW = 3, SW = 24, NCH = 4, FIFO_AW = 4;
   localparam int DST_WIDTH = 21, DST_AW = 4, R_FLG = 36, CREDIT_W = 4;
   localparam int TBL = 1 << DST_AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic manualCredit = 1'b0;
   logic autoCredit = 1'b1;
   logic autoPulse = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   cycleCnt = 0;
   int   flitsSeen = 0;
   logic [FW-1:0] expQ[$];
   logic [FW-1:0] seenFlits[$];
   int   flitCycles[$];
   logic [19:0] tblRoute [TBL];
   logic        tblLast [TBL];
   bit          tblValid = 0;
   int          modelRr = 0;

`ifdef SPK_OUT_MC_STATS_EN
   logic        statClr = 1'b0;
   logic [15:0] statDropCnt;
   logic [15:0] statFlitCnt;
`endif

   spk_out_mc_if #(.FW(FW), .SW(SW), .NCH(NCH), .DST_WIDTH(DST_WIDTH), .DST_AW(DST_AW)) bus ();

   spk_out_mc #(
      .FW(FW), .FTW(FTW), .SW(SW), .NCH(NCH), .FIFO_AW(FIFO_AW), .DST_WIDTH(DST_WIDTH),
      .DST_AW(DST_AW), .R_FLG(R_FLG), .CREDIT_W(CREDIT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef SPK_OUT_MC_STATS_EN
      .stat_clr(statClr),
      .stat_drop_cnt(statDropCnt),
      .stat_flit_cnt(statFlitCnt),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Free-running cycle index used to measure latencies.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // The NI hands back one credit the cycle after each flit when auto return is on.
   always @(posedge clk) autoPulse <= autoCredit && bus.flit_out_wr;
   assign bus.credit_in = manualCredit | autoPulse;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every emitted flit must be the next one the model predicted.
   always @(negedge clk) begin
      if (!rst && bus.flit_out_wr) begin
         flitsSeen++;
         flitCycles.push_back(cycleCnt);
         seenFlits.push_back(bus.flit_out);
         if (expQ.size() == 0) checkOutput("flit_expected", 64'(expQ.size() != 0), 64'd1);
         else checkOutput("flit_value", 64'(bus.flit_out), 64'(expQ.pop_front()));
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic modelSpike(input logic [SW-1:0] neuid);
      if (!tblValid) return;
      for (int a = 0; a < TBL; a++) begin
         expQ.push_back({3'b000, tblRoute[a], 12'h000, neuid});
         if (tblLast[a]) break;
      end
   endtask

   task automatic applyStimulus(input logic [NCH-1:0] fire, input logic [NCH*SW-1:0] neuid,
                                input logic cfgWe, input logic [FW-1:0] cfgData);
      bus.soma_fire  = fire;
      bus.soma_neuid = neuid;
      bus.cfg_we     = cfgWe;
      bus.cfg_wdata  = cfgData;
      tick(1);
      bus.soma_fire = '0;
      bus.cfg_we    = 1'b0;
   endtask

   task automatic writeTable(input int a, input logic [19:0] route, input logic last);
      bus.dst_we    = 1'b1;
      bus.dst_waddr = DST_AW'(a);
      bus.dst_wdata = {route, last};
      tick(1);
      bus.dst_we = 1'b0;
      tblRoute[a] = route;
      tblLast[a]  = last;
      tblValid    = 1;
   endtask

   task automatic readTable(input int a, input logic [DST_WIDTH-1:0] expected);
      bus.dst_re    = 1'b1;
      bus.dst_raddr = DST_AW'(a);
      tick(1);
      bus.dst_re = 1'b0;
      checkOutput("dst_rvalid_hi", 64'(bus.dst_rvalid), 64'd1);
      checkOutput("dst_rdata", 64'(bus.dst_rdata), 64'(expected));
      tick(1);
      checkOutput("dst_rvalid_lo", 64'(bus.dst_rvalid), 64'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      expQ.delete();
      tblValid = 0;
      modelRr  = 0;
      checkOutput("rst_flit_out_wr", 64'(bus.flit_out_wr), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_cfg_full", 64'(bus.cfg_full), 64'd0);
   endtask

   task automatic waitIdle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!bus.busy) break;
         tick(1);
      end
      checkOutput(name, 64'(bus.busy), 64'd0);
      checkOutput({name, "_drained"}, 64'(expQ.size()), 64'd0);
   endtask

   task automatic waitFlits(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (flitsSeen >= target) break;
         tick(1);
      end
   endtask

   task automatic fireAll(input logic [NCH*SW-1:0] nv);
      applyStimulus('1, nv, 1'b0, '0);
      for (int k = 0; k < NCH; k++) modelSpike(nv[((modelRr + k) % NCH)*SW +: SW]);
   endtask

   initial begin
      logic [NCH*SW-1:0] nv;
      logic [FW-1:0]     rd;
      int fireCycle, base, pulseCycle;

      bus.soma_fire = '0; bus.soma_neuid = '0; bus.cfg_we = 1'b0; bus.cfg_wdata = '0;
      bus.dst_we = 1'b0; bus.dst_waddr = '0; bus.dst_wdata = '0;
      bus.dst_re = 1'b0; bus.dst_raddr = '0;

      doReset();
      checkOutput("rst_flit_out", 64'(bus.flit_out), 64'd0);
      checkOutput("rst_dst_rvalid", 64'(bus.dst_rvalid), 64'd0);

      // Empty table after reset: the spike is discarded.
      nv = '0; nv[2*SW +: SW] = 24'h000055;
      applyStimulus(4'b0100, nv, 1'b0, '0);
      modelSpike(24'h000055);
      for (int i = 0; i < 4; i++) begin
         if (!bus.busy) break;
         tick(1);
      end
      checkOutput("empty_busy", 64'(bus.busy), 64'd0);
      tick(5);
      checkOutput("empty_noflit", 64'(flitsSeen), 64'd0);
`ifdef SPK_OUT_MC_STATS_EN
      checkOutput("stat_drop_empty", 64'(statDropCnt), 64'd1);
`endif

      // Two-entry multicast with readback.
      writeTable(0, 20'h0000A, 1'b0);
      writeTable(1, 20'h0000B, 1'b1);
      readTable(1, 21'h000017);
      readTable(0, 21'h000014);
      seenFlits.delete(); flitCycles.delete();
      nv = '0; nv[0 +: SW] = 24'h000123;
      fireCycle = cycleCnt;
      applyStimulus(4'b0001, nv, 1'b0, '0);
      modelSpike(24'h000123);
      waitIdle("mc_idle", 40);
      checkOutput("mc_count", 64'(seenFlits.size()), 64'd2);
      if (seenFlits.size() >= 2) begin
         checkOutput("mc_lat_first", 64'(flitCycles[0] - fireCycle), 64'd5);
         checkOutput("mc_lat_second", 64'(flitCycles[1] - fireCycle), 64'd8);
         checkOutput("mc_flit0", 64'(seenFlits[0]), 64'hA000000123);
         checkOutput("mc_flit1", 64'(seenFlits[1]), 64'hB000000123);
      end

      // Round robin from a fresh pointer, then a second burst.
      doReset();
      writeTable(0, 20'h00001, 1'b1);
      for (int b = 0; b < 2; b++) begin
         seenFlits.delete();
         for (int i = 0; i < NCH; i++) nv[i*SW +: SW] = SW'(24'h000100 * (b + 1) + i);
         fireAll(nv);
         waitIdle("rr_idle", 80);
         checkOutput("rr_count", 64'(seenFlits.size()), 64'd4);
         if (seenFlits.size() >= 4) begin
            rd = seenFlits[0];
            checkOutput("rr_first", 64'(rd[23:0]), 64'(24'h000100 * (b + 1)));
            rd = seenFlits[3];
            checkOutput("rr_last", 64'(rd[23:0]), 64'(24'h000103 + 24'h000100 * b));
         end
      end

      // READ flit passes through untouched.
      seenFlits.delete();
      rd = {3'b111, 56'h5A};
      applyStimulus('0, '0, 1'b1, rd);
      expQ.push_back(rd);
      waitIdle("read_idle", 20);
      checkOutput("read_count", 64'(seenFlits.size()), 64'd1);
      if (seenFlits.size() >= 1) checkOutput("read_flit", 64'(seenFlits[0]), 64'h0700_0000_0000_005A);

      // Credit starvation over a 16-entry table with no last flag.
      doReset();
      autoCredit = 1'b0;
      for (int a = 0; a < TBL; a++) writeTable(a, 20'h00100 + 20'(a), 1'b0);
      base = flitsSeen;
      nv = '0; nv[3*SW +: SW] = 24'hABCDEF;
      applyStimulus(4'b1000, nv, 1'b0, '0);
      modelSpike(24'hABCDEF);
      waitFlits(base + 15, 300);
      tick(10);
      checkOutput("starve_count", 64'(flitsSeen - base), 64'd15);
      checkOutput("starve_busy", 64'(bus.busy), 64'd1);
      pulseCycle = cycleCnt;
      manualCredit = 1'b1;
      tick(1);
      manualCredit = 1'b0;
      waitFlits(base + 16, 10);
      checkOutput("credit_one_more", 64'(flitsSeen - base), 64'd16);
      checkOutput("credit_latency", 64'(flitCycles[flitCycles.size()-1] - pulseCycle), 64'd2);
      waitIdle("wrap_idle", 10);
      tick(5);
      checkOutput("wrap_count", 64'(flitsSeen - base), 64'd16);

      // No credit left: stall, fill the FIFO to the almost-full mark, then reset.
      base = flitsSeen;
      nv = '0; nv[0 +: SW] = 24'h000077;
      applyStimulus(4'b0001, nv, 1'b0, '0);
      tick(4);
      for (int i = 0; i < 14; i++) applyStimulus('0, '0, 1'b1, {3'b111, 56'(i)});
      checkOutput("cfg_full_14", 64'(bus.cfg_full), 64'd0);
      applyStimulus('0, '0, 1'b1, {3'b111, 56'hEE});
      checkOutput("cfg_full_15", 64'(bus.cfg_full), 64'd1);
      checkOutput("stall_busy", 64'(bus.busy), 64'd1);
      doReset();
      tick(5);
      checkOutput("reset_drops_inflight", 64'(flitsSeen - base), 64'd0);

      // Second fire on a pending channel is dropped while cfg pushes hold off the grant.
      autoCredit = 1'b1;
      writeTable(15, 20'h0010F, 1'b0);
      tblValid = 1;
      seenFlits.delete();
      nv = '0; nv[1*SW +: SW] = 24'h111111;
      applyStimulus(4'b0010, nv, 1'b1, {3'b111, 56'h1});
      nv[1*SW +: SW] = 24'h222222;
      applyStimulus(4'b0010, nv, 1'b1, {3'b111, 56'h2});
      expQ.push_back({3'b111, 56'h1});
      expQ.push_back({3'b111, 56'h2});
      modelSpike(24'h111111);
      waitIdle("drop_idle", 200);
      checkOutput("drop_count", 64'(seenFlits.size()), 64'd18);
      if (seenFlits.size() >= 18) begin
         rd = seenFlits[17];
         checkOutput("drop_old_hold", 64'(rd[23:0]), 64'h111111);
      end
`ifdef SPK_OUT_MC_STATS_EN
      checkOutput("stat_drop_fire", 64'(statDropCnt), 64'd1);
      checkOutput("stat_flit", 64'(statFlitCnt), 64'd18);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
